// File: rtl/mux_scan_serializer.sv
// mux_scan_serializer
//   Sequencing stage around an external N:1 mux. It accepts an N-bit word over
//   a valid/ready handshake and holds it on the mux data inputs. It then steps
//   the mux select through every index and returns each selected bit as a
//   serial stream with valid/ready flow control and a last-beat marker.
//
// Parameters
//   N          word width / number of mux inputs (N >= 2)
//   SEL_W      select width (2**SEL_W >= N)
//   MSB_FIRST  0: scan index 0 -> N-1, 1: scan index N-1 -> 0
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   load_valid   upstream word valid
//   load_ready   block can accept a word (combinational, no bubble between words)
//   load_data    upstream word
//   mux_a        held word, drives mux data input
//   mux_s        current index, drives mux select
//   mux_y        mux output (mux_a[mux_s])
//   ser_valid    serial bit valid
//   ser_ready    downstream accepts bit
//   ser_data     serial bit, combinational copy of mux_y
//   ser_last     current beat is the final index of the word
//   busy         a word is being scanned
module mux_scan_serializer #(
  parameter int N         = 8,
  parameter int SEL_W     = 3,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [N-1:0]     load_data,
  output logic [N-1:0]     mux_a,
  output logic [SEL_W-1:0] mux_s,
  input  logic             mux_y,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_data,
  output logic             ser_last,
  output logic             busy
);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  localparam logic [SEL_W-1:0] START_IDX = (MSB_FIRST != 0) ? SEL_W'(N - 1) : '0;
  localparam logic [SEL_W-1:0] END_IDX   = (MSB_FIRST != 0) ? '0 : SEL_W'(N - 1);

  state_t           state;
  state_t           state_next;
  logic             load_fire;
  logic             beat;
  logic [SEL_W-1:0] step_idx;

  assign load_fire = load_valid && load_ready;
  assign beat      = ser_valid && ser_ready;
  assign ser_data  = mux_y;
  assign step_idx  = (MSB_FIRST != 0) ? (mux_s - SEL_W'(1)) : (mux_s + SEL_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ser_valid  = 1'b0;
    ser_last   = 1'b0;
    busy       = 1'b0;
    load_ready = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          state_next = SCAN;
        end
      end
      SCAN: begin
        ser_valid  = 1'b1;
        busy       = 1'b1;
        ser_last   = (mux_s == END_IDX);
        // Ready opens only on the accepted last beat, so a waiting word
        // loads in the same edge that retires the current one.
        load_ready = ser_last && ser_ready;
        if (ser_last && ser_ready && !load_valid) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Select only steps on a non-last beat, so it never leaves [0, N-1].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_a <= '0;
      mux_s <= '0;
    end else if (load_fire) begin
      mux_a <= load_data;
      mux_s <= START_IDX;
    end else if (beat && !ser_last) begin
      mux_s <= step_idx;
    end
  end

endmodule

// File: tb/tb_mux_scan_serializer.sv
module tb_mux_scan_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] lv = '0;
  logic [7:0] ld = '0;
  logic       sr = 1'b1;

  // instance 0: N=8 LSB-first, instance 1: N=8 MSB-first, instance 2: N=5 LSB-first
  logic       lr0, sv0, sd0, sl0, bz0, my0;
  logic [7:0] ma0;
  logic [2:0] ms0;
  logic       lr1, sv1, sd1, sl1, bz1, my1;
  logic [7:0] ma1;
  logic [2:0] ms1;
  logic       lr2, sv2, sd2, sl2, bz2, my2;
  logic [4:0] ma2;
  logic [2:0] ms2;

  int errors = 0;
  int checks = 0;
  int cur = 0;

  logic       c_lr, c_sv, c_sd, c_sl, c_bz;
  logic [7:0] c_a;
  logic [2:0] c_s;

  always #5 clk = ~clk;

  // external mux_nx1 models
  assign my0 = ma0[ms0];
  assign my1 = ma1[ms1];
  assign my2 = (ms2 < 3'd5) ? ma2[ms2] : 1'b0;

  mux_scan_serializer #(.N(8), .SEL_W(3), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .load_valid(lv[0]), .load_ready(lr0), .load_data(ld),
    .mux_a(ma0), .mux_s(ms0), .mux_y(my0), .ser_valid(sv0), .ser_ready(sr),
    .ser_data(sd0), .ser_last(sl0), .busy(bz0));

  mux_scan_serializer #(.N(8), .SEL_W(3), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst_n(rst_n), .load_valid(lv[1]), .load_ready(lr1), .load_data(ld),
    .mux_a(ma1), .mux_s(ms1), .mux_y(my1), .ser_valid(sv1), .ser_ready(sr),
    .ser_data(sd1), .ser_last(sl1), .busy(bz1));

  mux_scan_serializer #(.N(5), .SEL_W(3), .MSB_FIRST(0)) u_n5 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv[2]), .load_ready(lr2), .load_data(ld[4:0]),
    .mux_a(ma2), .mux_s(ms2), .mux_y(my2), .ser_valid(sv2), .ser_ready(sr),
    .ser_data(sd2), .ser_last(sl2), .busy(bz2));

  always_comb begin
    c_lr = lr0; c_sv = sv0; c_sd = sd0; c_sl = sl0; c_bz = bz0; c_a = ma0; c_s = ms0;
    case (cur)
      1: begin c_lr = lr1; c_sv = sv1; c_sd = sd1; c_sl = sl1; c_bz = bz1; c_a = ma1; c_s = ms1; end
      2: begin c_lr = lr2; c_sv = sv2; c_sd = sd2; c_sl = sl2; c_bz = bz2; c_a = {3'b000, ma2}; c_s = ms2; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(c_sv), 32'd0);
    check({tag, "_ready"}, 32'(c_lr), 32'd1);
    check({tag, "_busy"},  32'(c_bz), 32'd0);
    check({tag, "_last"},  32'(c_sl), 32'd0);
  endtask

  // Present a word at a negedge; it is accepted at the next posedge.
  task automatic start_word(input int inst, input logic [7:0] d);
    cur = inst;
    ld = d;
    lv[inst] = 1'b1;
    @(negedge clk);
    lv[inst] = 1'b0;
  endtask

  // Walk n beats with ser_ready high; seq[k] is the hand-computed k-th serial bit.
  task automatic scan_check(input string tag, input int n, input bit msb, input logic [15:0] seq);
    for (int k = 0; k < n; k++) begin
      check({tag, "_valid"}, 32'(c_sv), 32'd1);
      check({tag, "_sel"},   32'(c_s),  msb ? 32'(n - 1 - k) : 32'(k));
      check({tag, "_data"},  32'(c_sd), 32'(seq[k]));
      check({tag, "_last"},  32'(c_sl), 32'(k == n - 1));
      check({tag, "_ready"}, 32'(c_lr), 32'(k == n - 1));
      @(negedge clk);
    end
    check({tag, "_done_busy"}, 32'(c_bz), 32'd0);
    check({tag, "_done_valid"}, 32'(c_sv), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int beats;

    // reset state
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      cur = i;
      #1;
      check_idle("rst");
      check("rst_mux_a", 32'(c_a), 32'd0);
      check("rst_mux_s", 32'(c_s), 32'd0);
      check("rst_data",  32'(c_sd), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // single word LSB-first: 1,1,0,0,0,1,0,1
    start_word(0, 8'b1010_0011);
    scan_check("lsb", 8, 1'b0, 16'h00A3);

    // MSB-first: 1,0,1,0,0,0,1,1 in beat order
    start_word(1, 8'b1010_0011);
    scan_check("msb", 8, 1'b1, 16'h00C5);

    // non-power-of-2: 5'b10110 -> 0,1,1,0,1
    start_word(2, 8'b0001_0110);
    scan_check("n5", 5, 1'b0, 16'h0016);

    // backpressure: 8'h5C -> 0,0,1,1,1,0,1,0; stall 3 cycles at index 4
    start_word(0, 8'h5C);
    beats = 0;
    for (int cyc = 0; cyc < 11; cyc++) begin
      sr = !(cyc >= 4 && cyc <= 6);
      #1;
      if (!sr) begin
        check("bp_stall_sel",   32'(c_s),  32'd4);
        check("bp_stall_data",  32'(c_sd), 32'd1);
        check("bp_stall_valid", 32'(c_sv), 32'd1);
        check("bp_stall_ready", 32'(c_lr), 32'd0);
      end else if (c_sv) begin
        check("bp_sel", 32'(c_s), 32'(beats));
        check("bp_data", 32'(c_sd), (32'h5C >> beats) & 32'd1);
        beats++;
      end
      @(negedge clk);
    end
    sr = 1'b1;
    check("bp_beats", 32'(beats), 32'd8);
    check("bp_done_busy", 32'(c_bz), 32'd0);

    // back-to-back: A5 then 3C with load_valid held
    cur = 0;
    ld = 8'hA5;
    lv[0] = 1'b1;
    @(negedge clk);
    ld = 8'h3C;
    for (int k = 0; k < 16; k++) begin
      if (k == 8) lv[0] = 1'b0;
      #1;
      check("b2b_valid", 32'(c_sv), 32'd1);
      check("b2b_busy",  32'(c_bz), 32'd1);
      check("b2b_ready", 32'(c_lr), 32'((k == 7) || (k == 15)));
      check("b2b_data",  32'(c_sd), (32'h3CA5 >> k) & 32'd1);
      @(negedge clk);
    end
    check("b2b_done_busy", 32'(c_bz), 32'd0);

    // reset mid-word at index 3
    start_word(0, 8'hA3);
    repeat (3) @(negedge clk);
    check("mid_sel_before", 32'(c_s), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("mid_rst");
    check("mid_rst_mux_a", 32'(c_a), 32'd0);
    check("mid_rst_mux_s", 32'(c_s), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_word(0, 8'hFF);
    scan_check("after_rst", 8, 1'b0, 16'h00FF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_scan_serializer.md
# mux_scan_serializer

Sequencing stage that feeds an N:1 selection mux (`mux_nx1`) and consumes its output. It accepts an N-bit word over a valid/ready handshake, holds it on the mux data inputs, and steps the mux select through every index. It returns each selected bit as a serial stream with valid/ready flow control and a last-beat marker. Together with the mux it forms a parallel-to-serial converter in the combinational-mux datapath.

## Interface
Parameters:
- `N`, default 8: word width; number of mux inputs; N ≥ 2.
- `SEL_W`, default 3: select width; 2^SEL_W ≥ N.
- `MSB_FIRST`, default 0: 0 scans index 0→N-1; 1 scans N-1→0.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `load_valid`  in  1: upstream word valid.
- `load_ready`  out  1: block can accept a word.
- `load_data`  in  N: upstream word.
- `mux_a`  out  N: held word, drives mux data input `a`.
- `mux_s`  out  SEL_W: current index, drives mux select `s`.
- `mux_y`  in  1: mux output, equals `mux_a[mux_s]`.
- `ser_valid`  out  1: serial bit valid.
- `ser_ready`  in  1: downstream accepts bit.
- `ser_data`  out  1: serial bit; combinational copy of `mux_y`.
- `ser_last`  out  1: current beat is the final index of the word.
- `busy`  out  1: high while a word is being scanned.

## Operation
- FSM states:
  - IDLE: no word held. `ser_valid`=0, `load_ready`=1.
  - SCAN: word held. `ser_valid`=1.
- Load: when `load_valid && load_ready` at a clock edge:
  - `mux_a` ← `load_data`.
  - `mux_s` ← start index (0, or N-1 if `MSB_FIRST`).
  - State → SCAN.
- Beat: in SCAN, when `ser_valid && ser_ready` at a clock edge:
  - If not last: `mux_s` steps to the next index (+1, or −1 if `MSB_FIRST`).
  - If last: the word is done.
- Stall: `ser_ready`=0 holds `mux_s`, `mux_a`, and the state. `ser_data` stays stable.
- `ser_last` = SCAN && `mux_s` == end index (N-1, or 0 if `MSB_FIRST`).
- `load_ready` = IDLE || (SCAN && `ser_last` && `ser_ready`). It is combinational, so back-to-back words have no bubble.
- Last beat with a simultaneous load: the new word and start index load, and state stays SCAN.
- Last beat without a load: state → IDLE. `mux_a` and `mux_s` hold their values; they are don't-care to downstream.
- `load_valid` in SCAN before the last beat: not accepted. Upstream must hold the word.
- `busy` = (state == SCAN).
- Select arithmetic: `mux_s` never leaves [0, N-1]. There is no modular wrap past N-1 when N < 2^SEL_W.
- Reset (async assert, any state, including mid-word):
  - State → IDLE; the partial word is discarded.
  - `mux_a`=0, `mux_s`=0, `ser_valid`=0, `ser_last`=0, `busy`=0, `load_ready`=1.
  - `ser_data` follows `mux_y`, which is `mux_a[0]` = 0.
- Release is synchronous to `clk`. The first load can be accepted on the first rising edge after `rst_n` goes high.

## Timing
- Load-to-first-bit: the edge that accepts the load makes `ser_valid`=1 in the following cycle, with `ser_data` = bit at the start index (one cycle).
- Throughput: one bit per cycle while `ser_ready`=1. With `load_valid` held, there are N cycles per word and zero idle cycles between words.
- `ser_data` path: `mux_a`/`mux_s` registers → external mux → `ser_data`. This is purely combinational within one cycle; no register is inside this block on that path.
- All registered outputs change only on a rising `clk` edge or async `rst_n` assertion.

## Test plan
- Single word, LSB-first:
  - Stimulus: N=8, `load_data`=8'b1010_0011, `ser_ready`=1.
  - Required: serial bits 1,1,0,0,0,1,0,1 on 8 consecutive cycles, `mux_s` 0..7, `ser_last` only on `mux_s`=7, then `busy`=0.
- MSB-first:
  - Stimulus: `MSB_FIRST`=1, same word.
  - Required: bits 1,0,1,0,0,0,1,1, `mux_s` 7..0, `ser_last` at `mux_s`=0.
- Backpressure:
  - Stimulus: deassert `ser_ready` for 3 cycles at `mux_s`=4.
  - Required: `mux_s` stays 4, `ser_data` stays `load_data[4]`, `ser_valid` stays 1; the scan resumes at index 5 and 8 beats total are transferred.
- Back-to-back words:
  - Stimulus: 8'hA5 then 8'h3C with `load_valid` held.
  - Required: `load_ready` pulses only on the last beat of each word; 16 bits on 16 consecutive cycles; `busy` never drops between words.
- Reset mid-word:
  - Stimulus: assert `rst_n`=0 at `mux_s`=3, asynchronously between edges.
  - Required: `ser_valid`=0, `mux_s`=0, `mux_a`=0, `load_ready`=1 immediately; after release, a new word 8'hFF scans all ones from index 0.
- Non-power-of-2:
  - Stimulus: N=5, `SEL_W`=3, word 5'b10110.
  - Required: bits 0,1,1,0,1, `mux_s` never exceeds 4, `ser_last` at index 4.
